// File: rtl/hci_tcdm_bank_responder.sv
// Single-bank TCDM responder for the HCI memory port: byte-enabled
// read/write with one-cycle response; test-and-set enabled by HCI_BANK_TS_EN.
module hci_tcdm_bank_responder #(
    parameter int unsigned DW      = 32,
    parameter int unsigned BW      = 8,
    parameter int unsigned AW      = 10,
    parameter int unsigned N_WORDS = 1024,
    parameter int unsigned IW      = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [AW-1:0]    add_i,
    input  logic             wen_i,
    input  logic [DW-1:0]    data_i,
    input  logic [DW/BW-1:0] be_i,
    input  logic [IW-1:0]    id_i,
    input  logic             ts_set_i,
    output logic             r_valid_o,
    output logic [DW-1:0]    r_data_o,
    output logic [IW-1:0]    r_id_o,
    output logic             r_opc_o
);

    localparam int unsigned NB    = DW / BW;
    localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    logic [DW-1:0]    mem_q [N_WORDS];
    logic [DW-1:0]    mem_d [N_WORDS];
    logic             r_valid_q, r_valid_d;
    logic [DW-1:0]    r_data_q, r_data_d;
    logic [IW-1:0]    r_id_q, r_id_d;
    logic             r_opc_q, r_opc_d;

    logic             xfer;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             ts_wr;
    logic [IDX_W-1:0] ts_addr;

    assign xfer     = req_i & gnt_o;
    assign in_range = (32'(add_i) < N_WORDS);
    assign idx      = add_i[IDX_W-1:0];

`ifdef HCI_BANK_TS_EN
    typedef enum logic {
        IDLE,
        TSWR
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ts_addr_q, ts_addr_d;

    // Grant only from state and reset, never from the request.
    assign gnt_o   = ~rst_i & (state_q == IDLE);
    assign ts_addr = ts_addr_q;

    // Test-and-set sequencing: latch address, then one set-write cycle.
    always_comb begin
        state_d   = state_q;
        ts_addr_d = ts_addr_q;
        ts_wr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer & wen_i & ts_set_i & in_range) begin
                    state_d   = TSWR;
                    ts_addr_d = idx;
                end
            end
            TSWR: begin
                ts_wr   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and latched set-write address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ts_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            ts_addr_q <= ts_addr_d;
        end
    end
`else
    logic unused_ts;

    // Without test-and-set the bank never stalls.
    assign gnt_o     = ~rst_i;
    assign ts_wr     = 1'b0;
    assign ts_addr   = '0;
    assign unused_ts = ts_set_i;
`endif

    // Array update: set-write of all-ones, or a byte-enabled write.
    always_comb begin
        mem_d = mem_q;
        if (ts_wr) begin
            mem_d[ts_addr] = '1;
        end else if (xfer & ~wen_i & in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (be_i[k]) begin
                    mem_d[idx][k*BW +: BW] = data_i[k*BW +: BW];
                end
            end
        end
    end

    // Response one cycle after each transfer; fields hold between responses.
    always_comb begin
        r_valid_d = 1'b0;
        r_data_d  = r_data_q;
        r_id_d    = r_id_q;
        r_opc_d   = r_opc_q;
        if (xfer) begin
            r_valid_d = 1'b1;
            r_id_d    = id_i;
            r_opc_d   = ~in_range;
            r_data_d  = (wen_i & in_range) ? mem_q[idx] : '0;
        end
    end

    // Storage array, cleared on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_id_q    <= '0;
            r_opc_q   <= 1'b0;
        end else begin
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_id_q    <= r_id_d;
            r_opc_q   <= r_opc_d;
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_data_o  = r_data_q;
    assign r_id_o    = r_id_q;
    assign r_opc_o   = r_opc_q;

endmodule

// File: tb/tb_hci_tcdm_bank_responder.sv
// Randomized bench for hci_tcdm_bank_responder against a word-array model;
// follows HCI_BANK_TS_EN to expect test-and-set behaviour or not.
module tb_hci_tcdm_bank_responder;

`ifdef HCI_BANK_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [10:0] add_i;
    logic        wen_i;
    logic [31:0] data_i;
    logic [3:0]  be_i;
    logic [19:0] id_i;
    logic        ts_set_i;
    logic        r_valid_o;
    logic [31:0] r_data_o;
    logic [19:0] r_id_o;
    logic        r_opc_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [1024];
    bit          m_busy;
    logic [10:0] m_addr;
    logic        e_valid;
    logic [31:0] e_data;
    logic [19:0] e_id;
    logic        e_opc;

    hci_tcdm_bank_responder #(
        .DW(32), .BW(8), .AW(11), .N_WORDS(1024), .IW(20)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .add_i    (add_i),
        .wen_i    (wen_i),
        .data_i   (data_i),
        .be_i     (be_i),
        .id_i     (id_i),
        .ts_set_i (ts_set_i),
        .r_valid_o(r_valid_o),
        .r_data_o (r_data_o),
        .r_id_o   (r_id_o),
        .r_opc_o  (r_opc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_resp();
        chk("r_valid", 32'(r_valid_o), 32'(e_valid));
        chk("r_data", r_data_o, e_data);
        chk("r_id", 32'(r_id_o), 32'(e_id));
        chk("r_opc", 32'(r_opc_o), 32'(e_opc));
    endtask

    // One clock cycle: drive, check grant, advance model at the edge, check response.
    task automatic cycle(input bit rq, input bit we, input logic [10:0] ad,
                         input logic [31:0] d, input logic [3:0] b,
                         input logic [19:0] i, input bit ts);
        req_i    = rq;
        wen_i    = we;
        add_i    = ad;
        data_i   = d;
        be_i     = b;
        id_i     = i;
        ts_set_i = ts;
        #1;
        chk("gnt", 32'(gnt_o), 32'(!m_busy));
        @(posedge clk_i);
        e_valid = 1'b0;
        if (m_busy) begin
            m_mem[m_addr[9:0]] = 32'hFFFF_FFFF;
            m_busy = 1'b0;
        end else if (rq) begin
            e_valid = 1'b1;
            e_id    = i;
            e_opc   = (ad >= 11'd1024);
            e_data  = 32'h0;
            if (ad < 11'd1024) begin
                if (we) begin
                    e_data = m_mem[ad[9:0]];
                    if (ts && TS_EN) begin
                        m_busy = 1'b1;
                        m_addr = ad;
                    end
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (b[k]) m_mem[ad[9:0]][8*k +: 8] = d[8*k +: 8];
                end
            end
        end
        #1;
        chk_resp();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = 1'b0;
        for (int a = 0; a < 1024; a++) m_mem[a] = 32'h0;
        m_busy  = 1'b0;
        e_valid = 1'b0;
        e_data  = 32'h0;
        e_id    = 20'h0;
        e_opc   = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk_resp();
        @(posedge clk_i);
        #1;
        chk("rst_gnt_edge", 32'(gnt_o), 32'h0);
        chk_resp();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i    = 1'b0;
        req_i    = 1'b0;
        wen_i    = 1'b1;
        add_i    = '0;
        data_i   = '0;
        be_i     = '0;
        id_i     = '0;
        ts_set_i = 1'b0;
        #1;
        do_reset();

        // write then read back
        cycle(1, 0, 11'd5, 32'hDEADBEEF, 4'hF, 20'h3, 0);
        cycle(1, 1, 11'd5, 32'h0, 4'h0, 20'h7, 0);
        chk("wr_rd_data", r_data_o, 32'hDEADBEEF);

        // partial byte write
        cycle(1, 0, 11'd9, 32'h11223344, 4'hF, 20'h10, 0);
        cycle(1, 0, 11'd9, 32'hAABBCCDD, 4'b0101, 20'h11, 0);
        cycle(1, 1, 11'd9, 32'h0, 4'h0, 20'h12, 0);
        chk("be_merge", r_data_o, 32'h11BB33DD);

        // test-and-set on addr 2
        cycle(1, 1, 11'd2, 32'h0, 4'h0, 20'h20, 1);
        chk("ts_old", r_data_o, 32'h0);
        cycle(0, 1, 11'd2, 32'h0, 4'h0, 20'h21, 0);
        cycle(1, 1, 11'd2, 32'h0, 4'h0, 20'h22, 0);
        chk("ts_after", r_data_o, TS_EN ? 32'hFFFF_FFFF : 32'h0);

        // out of range
        cycle(1, 1, 11'd1024, 32'h0, 4'h0, 20'h30, 0);
        chk("oor_opc", 32'(r_opc_o), 32'h1);
        cycle(1, 0, 11'd1500, 32'h12345678, 4'hF, 20'h31, 0);
        cycle(1, 1, 11'd5, 32'h0, 4'h0, 20'h32, 1'b0);

        // reset during set-write
        cycle(1, 1, 11'd4, 32'h0, 4'h0, 20'h40, 1);
        do_reset();
        cycle(1, 1, 11'd4, 32'h0, 4'h0, 20'h41, 0);
        chk("rst_ts_addr4", r_data_o, 32'h0);

        // streaming reads
        for (int a = 0; a < 16; a++)
            cycle(1, 1, 11'(a), 32'h0, 4'h0, 20'(20'h100 + a), 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [10:0] ad;
            ad = ($urandom % 10 == 0) ? 11'(1024 + $urandom % 1024)
                                      : 11'($urandom % 16);
            cycle(($urandom % 4) != 0, $urandom % 2, ad, $urandom,
                  4'($urandom), 20'($urandom), ($urandom % 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hci_tcdm_bank_responder.md
# hci_tcdm_bank_responder

Memory-side responder for the HCI memory port: a single word-addressed TCDM bank that accepts granted requests from the log interconnect, performs byte-enabled reads and writes on an internal flop array and returns responses one cycle later with the request ID echoed. It also implements the atomic test-and-set sequence the crossbar signals per bank, blocking further requests for one cycle while the set-write completes. One instance sits on each `mems[i]` port of the interconnect, both in the cluster memory subsystem and as the bank model in interconnect benches.

## Interface
- `DW`, 32: data width in bits.
- `BW`, 8: byte width; byte-enable width is DW/BW.
- `AW`, 10: word-address width on `add_i`.
- `N_WORDS`, 1024: bank depth in words; must satisfy N_WORDS ≤ 2^AW.
- `IW`, 20: request/response ID width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  grant. A transfer occurs when `req_i & gnt_o`.
- `add_i`  in  AW  word address.
- `wen_i`  in  1  1 = read, 0 = write.
- `data_i`  in  DW  write data.
- `be_i`  in  DW/BW  byte enables. Used for writes only.
- `id_i`  in  IW  request ID.
- `ts_set_i`  in  1  test-and-set qualifier. Meaningful only with `wen_i = 1`.
- `r_valid_o`  out  1  response valid. One-cycle pulse.
- `r_data_o`  out  DW  read data.
- `r_id_o`  out  IW  echoed ID.
- `r_opc_o`  out  1  error flag; 1 = address out of range.

## Operation
- **Storage:** N_WORDS × DW flop array, cleared to 0 on reset.
- **Read** (transfer with `wen_i = 1`, `ts_set_i = 0`):
  - Next cycle: `r_data_o = mem[add_i]`, `r_valid_o = 1`, `r_id_o = id_i`, `r_opc_o = 0`.
- **Write** (transfer with `wen_i = 0`):
  - At the transfer edge, each byte k with `be_i[k] = 1` is written from `data_i`; other bytes are unchanged.
  - Next cycle: `r_valid_o = 1`, `r_data_o = 0`, `r_id_o = id_i`.
  - `ts_set_i` is ignored for writes.
- **Out of range** (`add_i ≥ N_WORDS`):
  - No array access of any kind.
  - Response next cycle with `r_opc_o = 1` and `r_data_o = 0`.
  - No test-and-set sequence is started.
- **FSM, two states:**
  - IDLE: `gnt_o = ~rst_i`.
    - A transfer with `wen_i & ts_set_i` and an in-range address latches the address and moves to TSWR.
    - The response is a normal read, returning the pre-set value.
  - TSWR: `gnt_o = 0`.
    - Writes all-ones to the latched address with all bytes enabled.
    - Produces no response.
    - Always returns to IDLE after one cycle.
- Between responses, `r_data_o`, `r_id_o` and `r_opc_o` hold their last values; `r_valid_o` is 0.
- **Reset:**
  - While `rst_i` is asserted, `gnt_o = 0` and all requests are ignored.
  - Reset during TSWR drops the pending set-write and returns the FSM to IDLE.

## Timing
- **Reset values:** `gnt_o = 0` (while in reset), `r_valid_o = 0`, `r_data_o = 0`, `r_id_o = 0`, `r_opc_o = 0`, FSM = IDLE, array = 0.
- `gnt_o` depends only on state and `rst_i`, never on `req_i`, so there is no combinational path from request to grant.
- **Latency:** response exactly 1 cycle after the transfer edge.
- **Throughput:** 1 transfer/cycle, except that a test-and-set costs 2 cycles (transfer + TSWR).
- Back-to-back write then read of the same word: the read returns the newly written data.
- A read in the cycle directly after TSWR returns all-ones.
- A request held through TSWR is accepted in the following IDLE cycle. Its inputs must stay stable until then (HCI valid/grant rule).

## Configuration
- Macro: `HCI_BANK_TS_EN`.
- **Defined:** the FSM and test-and-set behaviour are exactly as above.
- **Undefined:**
  - No FSM and no TSWR state.
  - `ts_set_i` is ignored; a read with `ts_set_i = 1` is a plain read.
  - `gnt_o = ~rst_i` at all times.
  - The array is never written except by explicit writes.

## Test plan
- Write 0xDEADBEEF to addr 5 with `be = 4'b1111`, id 0x3, then read addr 5 with id 0x7.
  - Responses on consecutive cycles.
  - Second response: `r_data = 0xDEADBEEF`, `r_id = 0x7`, `r_opc = 0`.
- Write 0x11223344 to addr 9 with `be = 4'b1111`, then 0xAABBCCDD with `be = 4'b0101`, then read addr 9 → `r_data = 0x11BB33DD`.
- Test-and-set read of addr 2 (contents 0) with `HCI_BANK_TS_EN` defined.
  - Response `r_data = 0`.
  - `gnt_o = 0` for exactly one cycle.
  - Next read of addr 2 returns 0xFFFFFFFF.
  - Repeat without the macro: the second read returns 0 and `gnt_o` never drops.
- Read addr 1024 with N_WORDS = 1024 → next cycle `r_valid = 1`, `r_opc = 1`, `r_data = 0`; the array is unchanged.
- Assert `rst_i` during TSWR after a test-and-set to addr 4.
  - Addr 4 reads 0 after reset.
  - All outputs are at reset values.
  - FSM is IDLE and `gnt_o = 1` once `rst_i` is released.
- Continuous reads of addresses 0..15 with `req_i` held high → 16 responses on 16 consecutive cycles with IDs matching in order.
